mem_arbiter: RTL

Single-port memory arbiter between the instruction-fetch side and the data side of the pipelined MIPS core. It grants the shared RAM port to one requester at a time and holds that grant until the RAM reports completion. It returns data and wait status to each side. It retries failed RAM accesses a bounded number of times. It sits between the caches (`datapath_cache_if` consumers) and the RAM model.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data sides.
// Data wins in IDLE, grants alternate after completions, and RAM errors are retried a bounded number of times.
module mem_arbiter #(
    parameter int          MAX_RETRY = 3,
    parameter logic [31:0] FAIL_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        errflag,
    output logic [7:0]  errcnt
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam int         RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IGNT  = 2'd1,
        S_DGNT  = 2'd2,
        S_RETRY = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [RW-1:0]   r_retry_cnt;
    logic            r_retry_dgnt;
    logic [7:0]      r_errcnt;

    logic            w_grant;
    logic            w_access;
    logic            w_error;
    logic            w_exhausted;
    logic            w_fail;
    logic            w_done;
    logic            w_do_retry;
    logic            w_dreq;

    assign w_dreq      = dREN | dWEN;
    assign w_grant     = (r_state == S_IGNT) || (r_state == S_DGNT);
    assign w_access    = w_grant && (ramstate == RAM_ACCESS);
    assign w_error     = w_grant && (ramstate == RAM_ERROR);
    assign w_exhausted = (r_retry_cnt == RW'(MAX_RETRY));
    assign w_fail      = w_error && w_exhausted;
    assign w_do_retry  = w_error && !w_exhausted;
    assign w_done      = w_access || w_fail;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_IDLE;
            r_retry_cnt  <= '0;
            r_retry_dgnt <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_done) begin
                r_retry_cnt <= '0;
            end else if (w_do_retry) begin
                r_retry_cnt  <= r_retry_cnt + 1'b1;
                r_retry_dgnt <= (r_state == S_DGNT);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_errcnt <= 8'd0;
        end else if (w_fail && (r_errcnt != 8'hFF)) begin
            r_errcnt <= r_errcnt + 8'd1;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_dreq) begin
                    w_next_state = S_DGNT;
                end else if (iREN) begin
                    w_next_state = S_IGNT;
                end
            end
            S_IGNT: begin
                if (w_done) begin
                    w_next_state = w_dreq ? S_DGNT : S_IDLE;
                end else if (w_do_retry) begin
                    w_next_state = S_RETRY;
                end
            end
            S_DGNT: begin
                if (w_done) begin
                    w_next_state = iREN ? S_IGNT : S_IDLE;
                end else if (w_do_retry) begin
                    w_next_state = S_RETRY;
                end
            end
            S_RETRY: begin
                w_next_state = r_retry_dgnt ? S_DGNT : S_IGNT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = ramload;
        dload    = ramload;
        case (r_state)
            S_IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = !w_done;
                if (w_fail) begin
                    iload = FAIL_WORD;
                end
            end
            S_DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = !dWEN;
                dwait    = !w_done;
                if (w_fail) begin
                    dload = FAIL_WORD;
                end
            end
            default: begin
            end
        endcase
    end

    assign errflag = w_fail;
    assign errcnt  = r_errcnt;

endmodule
